// File: rtl/system_pio_rsp_pkg.sv
// Shared register map and bit positions for the PIO response port.
// The command-side driver definitions use the same constants.
package system_pio_rsp_pkg;

  // Avalon-MM word addresses
  localparam logic [1:0] REG_DATA     = 2'd0;
  localparam logic [1:0] REG_STATUS   = 2'd1;
  localparam logic [1:0] REG_IRQ_MASK = 2'd2;
  localparam logic [1:0] REG_CONTROL  = 2'd3;

  // STATUS bit positions
  localparam int STS_NOT_EMPTY = 0;
  localparam int STS_FULL      = 1;
  localparam int STS_OVERFLOW  = 2;
  localparam int STS_COUNT_LSB = 4;
  localparam int STS_COUNT_MSB = 8;

  // CONTROL bit positions
  localparam int CTL_FLUSH   = 0;
  localparam int CTL_CLR_OVF = 2;

  // IRQ_MASK bit positions
  localparam int IRQ_NOT_EMPTY = 0;
  localparam int IRQ_OVERFLOW  = 1;
  localparam int IRQ_MASK_W    = 2;

  typedef struct packed {
    logic [22:0] rsvd_hi;
    logic [4:0]  count;
    logic        rsvd_3;
    logic        overflow;
    logic        full;
    logic        not_empty;
  } status_t;

  function automatic logic [31:0] pack_status(input logic [4:0] count,
                                              input logic overflow,
                                              input logic full,
                                              input logic not_empty);
    status_t s;
    s           = '0;
    s.count     = count;
    s.overflow  = overflow;
    s.full      = full;
    s.not_empty = not_empty;
    return s;
  endfunction

endpackage

// File: rtl/system_pio_rsp_fifo.sv
// Response word FIFO: circular storage with head/tail pointers and an
// occupancy count. Pop is ignored when empty; a push while full is only
// taken when a pop frees a slot in the same cycle. Flush wins over both.
module system_pio_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    head_ptr;
  logic [AW-1:0]    tail_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == CW'(0));
  assign full      = (count == CW'(DEPTH));
  assign do_pop    = pop & ~empty & ~flush;
  assign do_push   = push & (~full | do_pop) & ~flush;
  assign head_data = mem[head_ptr];

  // Storage is written on accepted pushes only and is never reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[tail_ptr] <= wr_data;
    end
  end

  // Pointer and count bookkeeping; power-of-two depth makes wrap free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (do_pop) begin
        head_ptr <= head_ptr + AW'(1);
      end
      if (do_push) begin
        tail_ptr <= tail_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/system_pio_rsp.sv
// PIO response port: fabric pushes response words into a FIFO, the CPU
// drains them through an Avalon-MM slave with zero wait states.
module system_pio_rsp
  import system_pio_rsp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             irq
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0]      head_data;
  logic [CW-1:0]         count;
  logic                  full;
  logic                  empty;
  logic                  overflow;
  logic [IRQ_MASK_W-1:0] irq_mask;

  logic                  rd_data_sel;
  logic                  wr_mask;
  logic                  wr_ctrl;
  logic                  flush;
  logic                  clr_ovf;
  logic                  pop_ok;
  logic                  ovf_set;
  logic                  unused_wdata;

  assign rd_data_sel = chipselect & ~read_n & (address == REG_DATA);
  assign wr_mask     = chipselect & ~write_n & (address == REG_IRQ_MASK);
  assign wr_ctrl     = chipselect & ~write_n & (address == REG_CONTROL);
  assign flush       = wr_ctrl & writedata[CTL_FLUSH];
  assign clr_ovf     = wr_ctrl & writedata[CTL_CLR_OVF];
  assign pop_ok      = rd_data_sel & ~empty;
  // A drop only happens when no pop frees a slot and no flush discards it.
  assign ovf_set     = in_valid & full & ~pop_ok & ~flush;
  assign in_ready    = ~full;

  assign unused_wdata = ^{writedata[31:3], writedata[1]};

  system_pio_rsp_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (in_valid),
    .pop       (rd_data_sel),
    .flush     (flush),
    .wr_data   (in_port),
    .head_data (head_data),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // Sticky overflow; a new drop outranks a coincident CPU clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

  // IRQ_MASK register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_mask <= '0;
    end else if (wr_mask) begin
      irq_mask <= writedata[IRQ_MASK_W-1:0];
    end
  end

  // Registered interrupt, one cycle behind the state that causes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq <= 1'b0;
    end else begin
      irq <= (irq_mask[IRQ_NOT_EMPTY] & ~empty) |
             (irq_mask[IRQ_OVERFLOW] & overflow);
    end
  end

  // Zero-wait-state read mux driven by address alone.
  always_comb begin
    readdata = '0;
    case (address)
      REG_DATA:     readdata = empty ? 32'd0 : 32'(head_data);
      REG_STATUS:   readdata = pack_status(5'(count), overflow, full, ~empty);
      REG_IRQ_MASK: readdata = 32'(irq_mask);
      default:      readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_system_pio_rsp.sv
module tb_system_pio_rsp;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] in_port;
  logic        in_valid;
  logic        in_ready;
  logic        irq;

  always #5 clk = ~clk;

  system_pio_rsp #(.DEPTH(DEPTH), .WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .read_n     (read_n),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .irq        (irq)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: queue of words plus sticky flag, mask and irq.
  logic [31:0] mq[$];
  bit          m_ovf;
  logic [1:0]  m_mask;
  bit          m_irq;

  typedef struct {
    logic [1:0]  a;
    logic        cs;
    logic        rn;
    logic        wn;
    logic [31:0] wd;
    logic        iv;
    logic [31:0] ip;
    logic [31:0] exp_rd;
    logic        exp_rdy;
    logic        exp_irq;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [1:0] a);
    logic [31:0] s;
    s = 32'd0;
    case (a)
      2'd0: s = (mq.size() == 0) ? 32'd0 : mq[0];
      2'd1: begin
        s[0]   = (mq.size() != 0);
        s[1]   = (mq.size() == DEPTH);
        s[2]   = m_ovf;
        s[8:4] = 5'(mq.size());
      end
      2'd2: s[1:0] = m_mask;
      default: s = 32'd0;
    endcase
    return s;
  endfunction

  task automatic set_in(input logic [1:0] a, input logic cs, input logic rn, input logic wn,
                        input logic [31:0] wd, input logic iv, input logic [31:0] ip);
    address    = a;
    chipselect = cs;
    read_n     = rn;
    write_n    = wn;
    writedata  = wd;
    in_valid   = iv;
    in_port    = ip;
    #1;
  endtask

  task automatic idle();
    set_in(2'd0, 1'b0, 1'b1, 1'b1, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic rd_status(input string name, input logic [31:0] exp);
    set_in(2'd1, 1'b1, 1'b0, 1'b1, 32'd0, 1'b0, 32'd0);
    chk(name, readdata, exp);
  endtask

  // Advance one clock, updating the model from the inputs now applied.
  task automatic tick();
    int sz;
    bit pop, ctrl, ovset, nirq;
    sz    = mq.size();
    pop   = chipselect && !read_n && address == 2'd0 && sz > 0;
    ctrl  = chipselect && !write_n && address == 2'd3;
    ovset = 0;
    nirq  = (m_mask[0] && sz > 0) || (m_mask[1] && m_ovf);
    if (ctrl && writedata[0]) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (in_valid) begin
        if (sz < DEPTH || pop) mq.push_back(in_port);
        else ovset = 1;
      end
    end
    if (ovset) m_ovf = 1;
    else if (ctrl && writedata[2]) m_ovf = 0;
    if (chipselect && !write_n && address == 2'd2) m_mask = writedata[1:0];
    m_irq = nirq;
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    mq.delete();
    m_ovf  = 0;
    m_mask = 2'd0;
    m_irq  = 0;
  endtask

  task automatic add(input logic [1:0] a, input logic cs, input logic rn, input logic wn,
                     input logic [31:0] wd, input logic iv, input logic [31:0] ip,
                     input logic [31:0] exp_rd, input logic exp_rdy, input logic exp_irq);
    vec_t v;
    v.a = a; v.cs = cs; v.rn = rn; v.wn = wn; v.wd = wd; v.iv = iv; v.ip = ip;
    v.exp_rd = exp_rd; v.exp_rdy = exp_rdy; v.exp_irq = exp_irq;
    tbl.push_back(v);
  endtask

  initial begin
    logic [1:0]  ra;
    logic        rcs, rrn, rwn, riv;
    logic [31:0] rwd, rip;

    reset = 1'b1;
    idle();
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // State straight out of reset
    set_in(2'd0, 1'b1, 1'b1, 1'b1, 32'd0, 1'b0, 32'd0);
    chk("rst_data", readdata, 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_irq", 32'(irq), 32'd0);
    rd_status("rst_status", 32'd0);
    set_in(2'd2, 1'b1, 1'b1, 1'b1, 32'd0, 1'b0, 32'd0);
    chk("rst_mask", readdata, 32'd0);
    set_in(2'd3, 1'b1, 1'b1, 1'b1, 32'd0, 1'b0, 32'd0);
    chk("rst_ctrl_read", readdata, 32'd0);
    idle();
    tick();

    // Basic push/read order
    add(2'd1, 1, 0, 1, 0, 1, 32'h11111111, 32'h00, 1, 0);
    add(2'd1, 1, 0, 1, 0, 1, 32'h22222222, 32'h11, 1, 0);
    add(2'd1, 1, 0, 1, 0, 0, 0,            32'h21, 1, 0);
    add(2'd0, 1, 0, 1, 0, 0, 0,            32'h11111111, 1, 0);
    add(2'd0, 1, 0, 1, 0, 0, 0,            32'h22222222, 1, 0);
    add(2'd1, 1, 0, 1, 0, 0, 0,            32'h00, 1, 0);
    add(2'd0, 1, 0, 1, 0, 0, 0,            32'h00, 1, 0);
    // Overflow with five pushes into four slots
    add(2'd1, 1, 0, 1, 0, 1, 32'hA0, 32'h00, 1, 0);
    add(2'd1, 1, 0, 1, 0, 1, 32'hA1, 32'h11, 1, 0);
    add(2'd1, 1, 0, 1, 0, 1, 32'hA2, 32'h21, 1, 0);
    add(2'd1, 1, 0, 1, 0, 1, 32'hA3, 32'h31, 1, 0);
    add(2'd1, 1, 0, 1, 0, 1, 32'hA4, 32'h43, 0, 0);
    add(2'd1, 1, 0, 1, 0, 0, 0,      32'h47, 0, 0);
    add(2'd0, 1, 0, 1, 0, 0, 0,      32'hA0, 0, 0);
    add(2'd0, 1, 0, 1, 0, 0, 0,      32'hA1, 1, 0);
    add(2'd0, 1, 0, 1, 0, 0, 0,      32'hA2, 1, 0);
    add(2'd0, 1, 0, 1, 0, 0, 0,      32'hA3, 1, 0);
    add(2'd1, 1, 0, 1, 0, 0, 0,      32'h04, 1, 0);
    add(2'd3, 1, 1, 0, 32'h4, 0, 0,  32'h00, 1, 0);
    add(2'd1, 1, 0, 1, 0, 0, 0,      32'h00, 1, 0);
    // Push into a full FIFO while popping
    add(2'd1, 1, 0, 1, 0, 1, 32'hC0, 32'h00, 1, 0);
    add(2'd1, 1, 0, 1, 0, 1, 32'hC1, 32'h11, 1, 0);
    add(2'd1, 1, 0, 1, 0, 1, 32'hC2, 32'h21, 1, 0);
    add(2'd1, 1, 0, 1, 0, 1, 32'hC3, 32'h31, 1, 0);
    add(2'd0, 1, 0, 1, 0, 1, 32'hB0, 32'hC0, 0, 0);
    add(2'd1, 1, 0, 1, 0, 0, 0,      32'h43, 0, 0);
    add(2'd0, 1, 0, 1, 0, 0, 0,      32'hC1, 0, 0);
    add(2'd0, 1, 0, 1, 0, 0, 0,      32'hC2, 1, 0);
    add(2'd0, 1, 0, 1, 0, 0, 0,      32'hC3, 1, 0);
    add(2'd0, 1, 0, 1, 0, 0, 0,      32'hB0, 1, 0);
    add(2'd1, 1, 0, 1, 0, 0, 0,      32'h00, 1, 0);

    foreach (tbl[i]) begin
      set_in(tbl[i].a, tbl[i].cs, tbl[i].rn, tbl[i].wn, tbl[i].wd, tbl[i].iv, tbl[i].ip);
      chk($sformatf("vec%0d_rd", i), readdata, tbl[i].exp_rd);
      chk($sformatf("vec%0d_ready", i), 32'(in_ready), 32'(tbl[i].exp_rdy));
      chk($sformatf("vec%0d_irq", i), 32'(irq), 32'(tbl[i].exp_irq));
      tick();
    end

    // irq timing on not_empty
    set_in(2'd2, 1, 1, 0, 32'h1, 0, 0); tick();
    set_in(2'd0, 0, 1, 1, 0, 1, 32'hD0); tick();
    idle();
    chk("irq_ne_lag", 32'(irq), 32'd0);
    tick();
    chk("irq_ne_high", 32'(irq), 32'd1);
    set_in(2'd0, 1, 0, 1, 0, 0, 0);
    chk("irq_pop_data", readdata, 32'hD0);
    tick();
    idle();
    chk("irq_pop_lag", 32'(irq), 32'd1);
    tick();
    chk("irq_pop_low", 32'(irq), 32'd0);

    // irq on overflow and its clear
    set_in(2'd2, 1, 1, 0, 32'h2, 0, 0); tick();
    for (int i = 0; i < 5; i++) begin
      set_in(2'd0, 0, 1, 1, 0, 1, 32'hE0 + 32'(i));
      tick();
    end
    rd_status("ovf_status", 32'h47);
    tick();
    chk("irq_ovf_high", 32'(irq), 32'd1);
    set_in(2'd3, 1, 1, 0, 32'h4, 0, 0); tick();
    idle();
    chk("irq_clr_lag", 32'(irq), 32'd1);
    tick();
    chk("irq_clr_low", 32'(irq), 32'd0);
    set_in(2'd3, 1, 1, 0, 32'h1, 0, 0); tick();
    rd_status("flush_after_ovf", 32'h00);

    // Overflow set wins over coincident clear
    for (int i = 0; i < 4; i++) begin
      set_in(2'd0, 0, 1, 1, 0, 1, 32'h50 + 32'(i));
      tick();
    end
    set_in(2'd3, 1, 1, 0, 32'h4, 1, 32'h5F); tick();
    rd_status("ovf_vs_clr", 32'h47);
    set_in(2'd3, 1, 1, 0, 32'h5, 0, 0); tick();
    rd_status("flush_and_clr", 32'h00);

    // Flush coincident with push
    for (int i = 0; i < 3; i++) begin
      set_in(2'd0, 0, 1, 1, 0, 1, 32'h60 + 32'(i));
      tick();
    end
    set_in(2'd3, 1, 1, 0, 32'h1, 1, 32'hEE); tick();
    rd_status("flush3_status", 32'h00);
    set_in(2'd0, 1, 0, 1, 0, 0, 0);
    chk("flush3_data", readdata, 32'd0);
    chk("flush3_ready", 32'(in_ready), 32'd1);
    tick();
    for (int i = 0; i < 4; i++) begin
      set_in(2'd0, 0, 1, 1, 0, 1, 32'h70 + 32'(i));
      tick();
    end
    set_in(2'd3, 1, 1, 0, 32'h1, 1, 32'hEF); tick();
    rd_status("flush_full_status", 32'h00);

    // Asynchronous reset in the middle of a push burst
    set_in(2'd2, 1, 1, 0, 32'h1, 0, 0); tick();
    for (int i = 0; i < 3; i++) begin
      set_in(2'd1, 1, 0, 1, 0, 1, 32'h80 + 32'(i));
      tick();
    end
    chk("prereset_irq", 32'(irq), 32'd1);
    chk("prereset_status", readdata, 32'h31);
    set_in(2'd1, 1, 0, 1, 0, 1, 32'h83);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_status", readdata, 32'd0);
    chk("async_rst_irq", 32'(irq), 32'd0);
    chk("async_rst_ready", 32'(in_ready), 32'd1);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle();
    tick();
    set_in(2'd0, 1, 0, 1, 0, 0, 0);
    chk("post_rst_data", readdata, 32'd0);
    chk("post_rst_irq", 32'(irq), 32'd0);
    tick();
    rd_status("post_rst_status", 32'd0);
    tick();

    // Randomised traffic against the model
    for (int n = 0; n < 2000; n++) begin
      ra  = 2'($urandom_range(0, 3));
      rcs = ($urandom_range(0, 3) != 0);
      rrn = 1'($urandom_range(0, 1));
      rwn = ($urandom_range(0, 7) != 0);
      rwd = $urandom;
      if (ra == 2'd3 && $urandom_range(0, 7) != 0) rwd[0] = 1'b0;
      riv = 1'($urandom_range(0, 1));
      rip = $urandom;
      set_in(ra, rcs, rrn, rwn, rwd, riv, rip);
      chk($sformatf("rand%0d_rd", n), readdata, m_read(ra));
      chk($sformatf("rand%0d_ready", n), 32'(in_ready), 32'(mq.size() < DEPTH));
      chk($sformatf("rand%0d_irq", n), 32'(irq), 32'(m_irq));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/system_pio_rsp.md
SYSTEM_PIO_RSP -- requirements
Module: system_pio_rsp

Interface
REQ-001 Parameters SHALL be: DEPTH, 4, response FIFO entries (power of two, 2..16); WIDTH, 32, response word width.
REQ-002 clk  input  1  single system clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 address  input  2  Avalon-MM slave word address.
REQ-005 chipselect  input  1  slave select.
REQ-006 read_n  input  1  active-low read strobe.
REQ-007 write_n  input  1  active-low write strobe.
REQ-008 writedata  input  32  CPU write data.
REQ-009 readdata  output  32  CPU read data, zero wait states.
REQ-010 in_port  input  WIDTH  response word from fabric.
REQ-011 in_valid  input  1  single-cycle strobe qualifying in_port.
REQ-012 in_ready  output  1  high when FIFO not full (advisory; no backpressure).
REQ-013 irq  output  1  level interrupt to CPU.

Function
REQ-014 Register map SHALL be: 0 DATA (R, head word), 1 STATUS (R), 2 IRQ_MASK (R/W, bits[1:0]), 3 CONTROL (W, reads 0).
REQ-015 STATUS SHALL be: bit0 not_empty, bit1 full, bit2 overflow (sticky), bits[8:4] count, other bits 0.
REQ-016 readdata SHALL be combinational from address; DATA reads head word when not empty, 0 when empty.
REQ-017 Push: in_valid high and not full SHALL write in_port at tail, tail+1, count+1 at next edge.
REQ-018 in_valid high while full SHALL drop the word and set overflow; FIFO contents unchanged.
REQ-019 Pop: chipselect & ~read_n & address==0 & not empty SHALL advance head, count-1 at next edge; pop on empty SHALL change nothing.
REQ-020 Simultaneous push and pop SHALL both take effect, count unchanged; when full the push is accepted (pop frees a slot in the same cycle), no overflow.
REQ-021 Simultaneous push and pop while empty: pop ignored, push accepted, count becomes 1.
REQ-022 Head/tail pointers SHALL wrap modulo DEPTH; count range 0..DEPTH.
REQ-023 Write to CONTROL bit0=1 SHALL flush (head=tail=count=0); bit2=1 SHALL clear overflow; both in the same write allowed.
REQ-024 Flush coincident with push SHALL win: push discarded, overflow not set.
REQ-025 Overflow set coincident with CPU clear SHALL leave overflow set.
REQ-026 Writes to addresses 0 and 1 SHALL be ignored; reads of address 3 return 0.
REQ-027 irq SHALL be registered: irq <= (mask[0] & not_empty) | (mask[1] & overflow), i.e. one cycle after the causing state.
REQ-028 in_ready SHALL equal ~full combinationally.

Reset
REQ-029 reset high SHALL asynchronously clear head, tail, count, overflow, IRQ_MASK and irq; FIFO storage need not be cleared.
REQ-030 After reset: readdata at address 0 = 0, STATUS = 0, in_ready = 1, irq = 0.
REQ-031 Reset mid-operation SHALL discard all queued words; pushes/pops in the reset cycle have no effect.

Structure
REQ-032 Register addresses, STATUS bit positions and CONTROL bit positions SHALL be constants in a shared package also used by the pio_cmd driver-side definitions.
REQ-033 FIFO storage and pointers SHALL be one sub-module, system_pio_rsp_fifo (push, pop, flush, head data, count, full, empty); register decode and irq stay in the top.

Verification
REQ-034 Reset, then push 0x11111111, 0x22222222 -> STATUS=0x21; DATA reads 0x11111111 then 0x22222222; STATUS=0x00.
REQ-035 DEPTH=4: push 5 words (0xA0..0xA4) -> full after 4th, in_ready=0, overflow=1, STATUS=0x47; reads return 0xA0..0xA3.
REQ-036 Full FIFO, push 0xB0 in same cycle as DATA read -> count stays 4, overflow stays 0, 0xB0 read last.
REQ-037 IRQ_MASK=0x1, push one word -> irq high 1 cycle after count becomes 1; read word -> irq low 1 cycle later; IRQ_MASK=0x2 with overflow, CONTROL=0x4 -> irq low next cycle.
REQ-038 Queue 3 words, CONTROL=0x1 coincident with in_valid -> count=0, overflow=0, DATA reads 0.
REQ-039 Assert reset asynchronously mid-burst of pushes -> STATUS=0, irq=0 immediately, no stale words after release.
